// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory stage: funct3 width codes,
// the FSM state type and small decode helpers.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

  // Any funct3 that is neither byte nor half is handled as a word access.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    if (is_byte(f3)) return 1'b0;
    if (is_half(f3)) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it; word (and undefined funct3) pass through.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result_o = {24'd0, byte_sel};
      F3_HU:   result_o = {16'd0, half_sel};
      F3_W:    result_o = rdata_i;
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through to writeback, issues aligned
// load/store requests over a valid/ready interface, aligns load data and
// flags misaligned accesses. EX is stalled while a request is in flight.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        misaligned
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, wb_data_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q, wb_rd_q;
  logic        is_load_q, wb_valid_q, misal_q;
  logic        accept, alu_wb, load_wb, misal_d;
  logic [31:0] load_data;

  load_extend u_ext (
    .rdata_i   (mem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (f3_q),
    .result_o  (load_data)
  );

  // Next-state and per-cycle event decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    alu_wb  = 1'b0;
    load_wb = 1'b0;
    misal_d = 1'b0;
    case (state_q)
      S_IDLE: if (ex_valid) begin
        if (ex_is_load || ex_is_store) begin
          if (addr_misaligned(ex_funct3, ex_result[1:0])) misal_d = 1'b1;
          else begin
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end else begin
          alu_wb = 1'b1;
        end
      end
      S_REQ:  if (mem_req_ready) state_d = is_load_q ? S_WAIT : S_IDLE;
      S_WAIT: if (mem_resp_valid) begin
        load_wb = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured request payload and registered writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      addr_lo_q  <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      is_load_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      misal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= alu_wb | load_wb;
      misal_q    <= misal_d;
      if (accept) begin
        addr_q    <= {ex_result[31:2], 2'b00};
        addr_lo_q <= ex_result[1:0];
        f3_q      <= ex_funct3;
        rd_q      <= ex_rd;
        is_load_q <= ex_is_load;
        if (ex_is_store) begin
          if (is_byte(ex_funct3)) begin
            wstrb_q <= 4'b0001 << ex_result[1:0];
            wdata_q <= {4{ex_store_data[7:0]}};
          end else if (is_half(ex_funct3)) begin
            wstrb_q <= 4'b0011 << ex_result[1:0];
            wdata_q <= {2{ex_store_data[15:0]}};
          end else begin
            wstrb_q <= 4'b1111;
            wdata_q <= ex_store_data;
          end
        end else begin
          wstrb_q <= 4'b0000;
          wdata_q <= '0;
        end
      end
      if (alu_wb) begin
        wb_data_q <= ex_result;
        wb_rd_q   <= ex_rd;
      end else if (load_wb) begin
        wb_data_q <= load_data;
        wb_rd_q   <= rd_q;
      end
    end
  end

  assign stall         = (state_q != S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_we        = (state_q == S_REQ) && !is_load_q;
  assign mem_addr      = addr_q;
  assign mem_wstrb     = wstrb_q;
  assign mem_wdata     = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign misaligned    = misal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of ALU/load/store/misaligned
// operations with hand-computed results, plus reset and spurious-response
// sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_is_load, ex_is_store;
  logic [4:0]  ex_rd;
  logic        stall, mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic        mem_we, mem_resp_valid, wb_valid, misaligned;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_funct3(ex_funct3), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_rd(ex_rd), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_MIS = 3;
  localparam int NV = 16;

  typedef struct {
    int          kind;
    logic [31:0] result, sdata, rdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          rwait, dwait;
    logic [31:0] exp_data, exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t        vecs[NV];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_wb = 32'd0;

  function automatic vec_t mk(input int kind, input logic [31:0] result, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic [2:0] f3, input logic [4:0] rd,
                              input int rwait, input int dwait, input logic [31:0] exp_data,
                              input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.kind = kind; v.result = result; v.sdata = sdata; v.rdata = rdata; v.f3 = f3; v.rd = rd;
    v.rwait = rwait; v.dwait = dwait; v.exp_data = exp_data; v.exp_addr = exp_addr;
    v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    ex_valid      = 1'b1;
    ex_result     = v.result;
    ex_store_data = v.sdata;
    ex_funct3     = v.f3;
    ex_is_load    = (v.kind == K_LD) || (v.kind == K_MIS && v.sdata == 32'd0);
    ex_is_store   = (v.kind == K_ST) || (v.kind == K_MIS && v.sdata != 32'd0);
    ex_rd         = v.rd;
    @(negedge clk);
    case (v.kind)
      K_ALU: begin
        ex_valid = 1'b0;
        chk({t, " alu wb_valid"}, 32'(wb_valid), 32'd1);
        chk({t, " alu wb_data"}, wb_data, v.exp_data);
        chk({t, " alu wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({t, " alu stall"}, 32'(stall), 32'd0);
        chk({t, " alu req_valid"}, 32'(mem_req_valid), 32'd0);
        last_wb = v.exp_data;
      end
      K_MIS: begin
        ex_valid = 1'b0;
        chk({t, " mis pulse"}, 32'(misaligned), 32'd1);
        chk({t, " mis req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({t, " mis wb_valid"}, 32'(wb_valid), 32'd0);
        chk({t, " mis stall"}, 32'(stall), 32'd0);
        chk({t, " mis wb_data hold"}, wb_data, last_wb);
      end
      default: begin
        chk({t, " stall"}, 32'(stall), 32'd1);
        chk({t, " req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({t, " addr"}, mem_addr, v.exp_addr);
        chk({t, " we"}, 32'(mem_we), (v.kind == K_ST) ? 32'd1 : 32'd0);
        if (v.kind == K_ST) begin
          chk({t, " wstrb"}, 32'(mem_wstrb), 32'(v.exp_strb));
          chk({t, " wdata"}, mem_wdata, v.exp_wdata);
        end
        for (int k = 0; k < v.rwait; k++) begin
          mem_resp_valid = 1'b1;          // must be ignored while in REQ
          mem_rdata      = 32'hDEAD_0000;
          @(negedge clk);
          chk({t, " req held"}, 32'(mem_req_valid), 32'd1);
          chk({t, " req stall"}, 32'(stall), 32'd1);
          chk({t, " addr held"}, mem_addr, v.exp_addr);
          chk({t, " req no wb"}, 32'(wb_valid), 32'd0);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({t, " post-hs req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({t, " post-hs wb_valid"}, 32'(wb_valid), 32'd0);
        if (v.kind == K_ST) begin
          ex_valid = 1'b0;
          chk({t, " st stall"}, 32'(stall), 32'd0);
          chk({t, " st we off"}, 32'(mem_we), 32'd0);
          chk({t, " st wb_data hold"}, wb_data, last_wb);
        end else begin
          chk({t, " wait stall"}, 32'(stall), 32'd1);
          for (int k = 0; k < v.dwait; k++) begin
            @(negedge clk);
            chk({t, " wait stall"}, 32'(stall), 32'd1);
            chk({t, " wait no wb"}, 32'(wb_valid), 32'd0);
          end
          mem_resp_valid = 1'b1;
          mem_rdata      = v.rdata;
          @(negedge clk);
          mem_resp_valid = 1'b0;
          ex_valid       = 1'b0;
          chk({t, " ld wb_valid"}, 32'(wb_valid), 32'd1);
          chk({t, " ld wb_data"}, wb_data, v.exp_data);
          chk({t, " ld wb_rd"}, 32'(wb_rd), 32'(v.rd));
          chk({t, " ld stall"}, 32'(stall), 32'd0);
          last_wb = v.exp_data;
        end
      end
    endcase
    @(negedge clk);
    chk({t, " wb pulse end"}, 32'(wb_valid), 32'd0);
    chk({t, " mis pulse end"}, 32'(misaligned), 32'd0);
    chk({t, " idle req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({t, " wb_data hold"}, wb_data, last_wb);
  endtask

  initial begin
    // kind, result, sdata (nonzero marks a misaligned store), rdata, f3, rd,
    // ready waits, resp waits, exp wb_data, exp addr, exp wstrb, exp wdata
    vecs[0]  = mk(K_ALU, 32'h0000_002A, 0, 0, 3'b000, 5, 0, 0, 32'h0000_002A, 0, 4'h0, 0);
    vecs[1]  = mk(K_LD, 32'h0000_0103, 0, 32'h80FF_1234, 3'b000, 7, 2, 1, 32'hFFFF_FF80, 32'h100, 4'h0, 0);
    vecs[2]  = mk(K_LD, 32'h0000_0102, 0, 32'hBEEF_0000, 3'b101, 8, 0, 0, 32'h0000_BEEF, 32'h100, 4'h0, 0);
    vecs[3]  = mk(K_ST, 32'h0000_0201, 32'h0000_00AB, 0, 3'b000, 4, 1, 0, 0, 32'h200, 4'b0010, 32'hABAB_ABAB);
    vecs[4]  = mk(K_MIS, 32'h0000_0102, 0, 0, 3'b010, 6, 0, 0, 0, 0, 4'h0, 0);
    vecs[5]  = mk(K_LD, 32'h0000_0106, 0, 32'h8001_7FFF, 3'b001, 9, 0, 0, 32'hFFFF_8001, 32'h104, 4'h0, 0);
    vecs[6]  = mk(K_LD, 32'h0000_0101, 0, 32'h1234_F0AA, 3'b100, 10, 1, 2, 32'h0000_00F0, 32'h100, 4'h0, 0);
    vecs[7]  = mk(K_ST, 32'h0000_0302, 32'h1234_5678, 0, 3'b001, 4, 0, 0, 0, 32'h300, 4'b1100, 32'h5678_5678);
    vecs[8]  = mk(K_ST, 32'h0000_0404, 32'hDEAD_BEEF, 0, 3'b010, 4, 2, 0, 0, 32'h404, 4'b1111, 32'hDEAD_BEEF);
    vecs[9]  = mk(K_MIS, 32'h0000_0101, 32'h0000_1111, 0, 3'b001, 6, 0, 0, 0, 0, 4'h0, 0);
    vecs[10] = mk(K_LD, 32'h0000_0208, 0, 32'hCAFE_F00D, 3'b010, 31, 0, 1, 32'hCAFE_F00D, 32'h208, 4'h0, 0);
    vecs[11] = mk(K_LD, 32'h0000_020C, 0, 32'h8765_4321, 3'b011, 3, 1, 0, 32'h8765_4321, 32'h20C, 4'h0, 0);
    vecs[12] = mk(K_MIS, 32'h0000_020E, 0, 0, 3'b111, 6, 0, 0, 0, 0, 4'h0, 0);
    vecs[13] = mk(K_ALU, 32'hFFFF_0001, 0, 0, 3'b010, 1, 0, 0, 32'hFFFF_0001, 0, 4'h0, 0);
    vecs[14] = mk(K_LD, 32'h0000_0100, 0, 32'h0000_007F, 3'b000, 2, 0, 0, 32'h0000_007F, 32'h100, 4'h0, 0);
    vecs[15] = mk(K_ST, 32'h0000_0500, 32'h1122_3344, 0, 3'b110, 4, 0, 0, 0, 32'h500, 4'b1111, 32'h1122_3344);

    rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_funct3 = '0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_rd = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst we", 32'(mem_we), 32'd0);
    chk("rst wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst misaligned", 32'(misaligned), 32'd0);
    rst = 1'b0;

    // Response while IDLE is ignored
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("idle resp wb_valid", 32'(wb_valid), 32'd0);
    chk("idle resp stall", 32'(stall), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset while in WAIT: the later response must not write back
    ex_valid = 1'b1; ex_result = 32'h0000_0300; ex_funct3 = 3'b010;
    ex_is_load = 1'b1; ex_is_store = 1'b0; ex_rd = 5'd12;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("wait-rst stall before", 32'(stall), 32'd1);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("wait-rst stall", 32'(stall), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("wait-rst wb_valid", 32'(wb_valid), 32'd0);
    chk("wait-rst wb_data", wb_data, 32'd0);
    @(negedge clk);
    chk("wait-rst wb_valid late", 32'(wb_valid), 32'd0);

    // Reset while in REQ: request dropped
    ex_valid = 1'b1; ex_result = 32'h0000_0400; ex_store_data = 32'h0BAD_F00D;
    ex_funct3 = 3'b010; ex_is_load = 1'b0; ex_is_store = 1'b1; ex_rd = 5'd0;
    @(negedge clk);
    chk("req-rst req_valid before", 32'(mem_req_valid), 32'd1);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("req-rst req_valid", 32'(mem_req_valid), 32'd0);
    chk("req-rst we", 32'(mem_we), 32'd0);
    chk("req-rst wstrb", 32'(mem_wstrb), 32'd0);
    chk("req-rst addr", mem_addr, 32'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("req-rst stall", 32'(stall), 32'd0);
    chk("req-rst wb_valid", 32'(wb_valid), 32'd0);

    // Recovery after reset
    last_wb = 32'd0;
    run_vec(100, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 ex_valid  input  1  EX result valid this cycle.
REQ-004 ex_result  input  32  ALU output: effective address for load/store, else writeback value.
REQ-005 ex_store_data  input  32  rs2 value for stores.
REQ-006 ex_funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ex_is_load, ex_is_store  input  1 each  op type; never both high.
REQ-008 ex_rd  input  5  destination register.
REQ-009 stall  output  1  high = EX holds all ex_* inputs stable.
REQ-010 mem_req_valid  output  1; mem_req_ready  input  1  request handshake.
REQ-011 mem_addr  output  32; mem_we  output  1; mem_wstrb  output  4; mem_wdata  output  32  request payload.
REQ-012 mem_resp_valid  input  1; mem_rdata  input  32  load response.
REQ-013 wb_valid  output  1; wb_data  output  32; wb_rd  output  5  registered writeback.
REQ-014 misaligned  output  1  one-cycle fault pulse.

Function
REQ-015 States IDLE, REQ, WAIT; ex_* accepted only in IDLE with ex_valid=1.
REQ-016 Non-memory op in IDLE: wb_valid=1, wb_data=ex_result, wb_rd=ex_rd on the next cycle (latency 1); state remains IDLE.
REQ-017 Aligned load/store in IDLE: capture address, data, funct3, rd, type; next state REQ.
REQ-018 stall = 1 whenever state is REQ or WAIT, else 0.
REQ-019 REQ: mem_req_valid=1, payload constant until mem_req_ready=1; on handshake, store -> IDLE, load -> WAIT.
REQ-020 mem_addr = {addr[31:2],2'b00}; mem_we=1 for stores only.
REQ-021 Store strobes: B 4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111; mem_wdata = byte replicated x4, half replicated x2, word as-is.
REQ-022 Stores produce no wb_valid.
REQ-023 WAIT: on mem_resp_valid, select byte/half by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU), word unchanged; wb_valid=1 with that data and captured rd next cycle; state -> IDLE.
REQ-024 mem_resp_valid in IDLE or REQ is ignored.
REQ-025 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no request, misaligned=1 next cycle, wb_valid=0, state stays IDLE.
REQ-026 wb_valid and misaligned are single-cycle pulses; wb_data/wb_rd hold last values otherwise.
REQ-027 Undefined funct3 on load/store is treated as W.

Reset
REQ-028 rst forces IDLE; stall, mem_req_valid, mem_we, wb_valid, misaligned = 0; mem_wstrb=0; mem_addr, mem_wdata, wb_data = 0; wb_rd = 0.
REQ-029 rst asserted in REQ or WAIT abandons the transaction: request dropped, later response ignored, no writeback.

Structure
REQ-030 Shared package holds funct3 width constants and the state enumeration, reused by decode.
REQ-031 One combinational sub-module load_extend (rdata, addr[1:0], funct3 -> 32-bit result), reused by the bench model.

Verification
REQ-032 ALU op ex_result=0x0000_002A, rd=5 -> next cycle wb_valid=1, wb_data=0x2A, wb_rd=5, stall=0.
REQ-033 LB addr 0x103, rdata 0x80FF_1234, ready after 2 waits, resp after 1 -> wb_data=0xFFFF_FF80; stall high throughout.
REQ-034 LHU addr 0x102, rdata 0xBEEF_0000 -> wb_data=0x0000_BEEF.
REQ-035 SB addr 0x201, store_data 0x0000_00AB -> mem_addr=0x200, wstrb=0010, wdata=0xABAB_ABAB, mem_we=1, no wb_valid.
REQ-036 LW addr 0x102 -> misaligned pulse, mem_req_valid never high, wb_valid=0.
REQ-037 rst in WAIT then mem_resp_valid -> IDLE, wb_valid stays 0.
